// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state/frame encodings, key code constants and the row/column key map.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REL_DB} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;

    localparam logic [3:0] KEY_PRINT = 4'd7;
    localparam logic [3:0] KEY_REPRO = 4'd8;
    localparam logic [3:0] KEY_LOCK  = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd14;
    localparam logic [3:0] KEY_HASH  = 4'd15;

    // Indexed by {row, col}; rows top to bottom, columns left to right.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'd1,      4'd2,      4'd3,     4'd10,
        4'd4,      4'd5,      4'd6,     4'd11,
        KEY_PRINT, KEY_REPRO, KEY_LOCK, 4'd12,
        KEY_STAR,  4'd0,      KEY_HASH, 4'd13
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: col_n synchronizer, row drive rotation and per-frame key accumulation.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       frame_done,
    output frame_t     frame_res,
    output logic [3:0] frame_code
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d, hits_q, hits_d, col_idx;
    logic [3:0]    row_n_q, row_n_d, meta_q, sync_q, code_q, code_d, hot, row_code;
    logic [2:0]    row_hits, total;
    logic          tc, first;

    // hits_q saturates at 2: anything beyond one intersection is already MULTI.
    always_comb begin
        tc         = div_q == DW'(SCAN_DIV - 1);
        hot        = ~sync_q;
        row_hits   = 3'(hot[0]) + 3'(hot[1]) + 3'(hot[2]) + 3'(hot[3]);
        col_idx    = hot[0] ? 2'd0 : hot[1] ? 2'd1 : hot[2] ? 2'd2 : 2'd3;
        row_code   = key_code(row_q, col_idx);
        first      = hits_q == 2'd0 && row_hits == 3'd1;
        total      = 3'(hits_q) + row_hits;
        frame_done = tc && row_q == 2'd3;
        frame_res  = total == 3'd0 ? NONE : total == 3'd1 ? SINGLE : MULTI;
        frame_code = first ? row_code : code_q;
        div_d      = tc ? '0 : div_q + 1'b1;
        row_d      = tc ? row_q + 2'd1 : row_q;
        row_n_d    = tc ? {row_n_q[2:0], row_n_q[3]} : row_n_q;
        hits_d     = !tc ? hits_q : frame_done ? 2'd0 : total > 3'd2 ? 2'd2 : total[1:0];
        code_d     = !tc ? code_q : frame_done ? 4'd0 : frame_code;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q   <= '0;
            row_q   <= 2'd0;
            row_n_q <= 4'b1110;
            meta_q  <= 4'hF;
            sync_q  <= 4'hF;
            hits_q  <= 2'd0;
            code_q  <= 4'd0;
        end else begin
            div_q   <= div_d;
            row_q   <= row_d;
            row_n_q <= row_n_d;
            meta_q  <= col_n;
            sync_q  <= meta_q;
            hits_q  <= hits_d;
            code_q  <= code_d;
        end
    end

    assign row_n = row_n_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: frame-level debounce FSM producing one rdy pulse per accepted key press.
// Build option KEYPAD_AUTOREPEAT_EN re-pulses rdy every REPEAT_FRAMES frames while the key stays down.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    , parameter int REPEAT_FRAMES = 64
`endif
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypress,
    output logic       rdy,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    state_t        state_q, state_d;
    frame_t        frame_res;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d, keypress_q, keypress_d, frame_code;
    logic          rdy_q, rdy_d, frame_done, single;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

    keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk        (clk),
        .resetN     (resetN),
        .col_n      (col_n),
        .row_n      (row_n),
        .frame_done (frame_done),
        .frame_res  (frame_res),
        .frame_code (frame_code)
    );

    always_comb begin
        single     = frame_res == SINGLE;
        cnt_inc    = cnt_q == CW'(DEBOUNCE_FRAMES) ? cnt_q : cnt_q + 1'b1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        keypress_d = keypress_q;
        rdy_d      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_inc    = rep_q == RW'(REPEAT_FRAMES) ? rep_q : rep_q + 1'b1;
        rep_d      = rep_q;
`endif
        if (frame_done) begin
            case (state_q)
                IDLE: if (single) begin
                    cand_d  = frame_code;
                    cnt_d   = CW'(1);
                    state_d = DEBOUNCE;
                end
                DEBOUNCE: if (single && frame_code == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
                        keypress_d = cand_q;
                        rdy_d      = 1'b1;
                        cnt_d      = '0;
                        state_d    = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d      = '0;
`endif
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                HELD: if (frame_res == NONE) begin
                    cnt_d   = CW'(1);
                    state_d = REL_DB;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d = single && frame_code == keypress_q ? rep_inc : '0;
                    if (single && frame_code == keypress_q && rep_inc == RW'(REPEAT_FRAMES)) begin
                        rdy_d = 1'b1;
                        rep_d = '0;
                    end
`endif
                end
                REL_DB: if (frame_res == NONE) begin
                    cnt_d   = cnt_inc == CW'(DEBOUNCE_FRAMES) ? '0 : cnt_inc;
                    state_d = cnt_inc == CW'(DEBOUNCE_FRAMES) ? IDLE : REL_DB;
                end else begin
                    cnt_d   = '0;
                    state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'd0;
            keypress_q <= 4'd0;
            rdy_q      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            keypress_q <= keypress_d;
            rdy_q      <= rdy_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign keypress = keypress_q;
    assign rdy      = rdy_q;
    assign key_held = state_q == HELD || state_q == REL_DB;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: physical keypad model plus frame-level press/release reference, checked every cycle.
module tb_keypad_scan_debounce;

    localparam int DF = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RF = 4;
    int rep;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  col_n, row_n, keypress;
    logic        rdy, key_held;
    logic [15:0] mask;
    logic [3:0]  rows [4];
    logic [3:0]  kp_exp, row_exp;
    logic        rdy_exp, down;
    int          n_checks, n_errors, cyc, run, run_key, rel;
    int          key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scan_debounce #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (DF)
`ifdef KEYPAD_AUTOREPEAT_EN
        , .REPEAT_FRAMES (RF)
`endif
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .col_n    (col_n),
        .row_n    (row_n),
        .keypress (keypress),
        .rdy      (rdy),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; undriven columns float high.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && mask[r*4+c]) col_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic model_reset();
        cyc = 0; run = 0; run_key = 0; rel = 0; down = 1'b0;
        kp_exp = 4'd0; rdy_exp = 1'b0;
        for (int r = 0; r < 4; r++) rows[r] = 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep = 0;
`endif
    endtask

    // One full scan: accept after DF same-key frames, re-arm after DF empty frames.
    task automatic model_frame();
        int n, k;
        n = 0; k = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (rows[r][c]) begin n++; k = key_map[r*4+c]; end
        if (!down) begin
            if (n == 1 && (run == 0 || k == run_key)) begin
                if (run == 0) run_key = k;
                run++;
                if (run == DF) begin
                    down = 1'b1; rel = 0; run = 0; kp_exp = 4'(k); rdy_exp = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep = 0;
`endif
                end
            end else run = 0;
        end else if (n == 0) begin
            rel++;
            if (rel == DF) begin down = 1'b0; rel = 0; end
        end else if (rel > 0) begin
            rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep = 0;
`endif
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (n == 1 && 4'(k) == kp_exp) begin
                rep++;
                if (rep == RF) begin rep = 0; rdy_exp = 1'b1; end
            end else rep = 0;
`endif
        end
    endtask

    // Row r is read through the synchronizer from col_n two cycles into its drive window.
    task automatic step();
        @(posedge clk);
        cyc++;
        rdy_exp = 1'b0;
        if (cyc % 4 == 2) rows[(cyc/4)%4] = mask[((cyc/4)%4)*4 +: 4];
        if (cyc % 16 == 0) model_frame();
        row_exp = 4'hF ^ (4'h1 << ((cyc / 4) % 4));
        @(negedge clk);
        check("rdy", {3'b0, rdy}, {3'b0, rdy_exp});
        check("keypress", keypress, kp_exp);
        check("key_held", {3'b0, key_held}, {3'b0, down});
        check("row_n", row_n, row_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_rdy", {3'b0, rdy}, 4'd0);
        check("rst_keypress", keypress, 4'd0);
        check("rst_key_held", {3'b0, key_held}, 4'd0);
        resetN = 1'b1;
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        mask = m;
        repeat (n) step();
    endtask

    task automatic bounce(input logic [15:0] m, input int n, input int p);
        for (int i = 0; i < n; i++) begin
            mask = ((i / p) % 2 == 0) ? m : 16'h0;
            step();
        end
    endtask

    initial begin
        logic [15:0] m;
        int kind;
        n_checks = 0; n_errors = 0;
        resetN = 1'b0; mask = 16'h0;
        do_reset();
        hold(16'h0, 40);
        hold(kbit(2, 2), 20 * 16 + 60);
        hold(16'h0, 80);
        bounce(kbit(2, 1), 32, 5);
        hold(kbit(2, 1), 100);
        hold(16'h0, 80);
        hold(kbit(0, 0) | kbit(1, 1), 100);
        hold(kbit(0, 0), 100);
        hold(16'h0, 80);
        hold(kbit(2, 0), 80);
        hold(16'h0, 16);
        hold(kbit(2, 0), 80);
        hold(16'h0, 64);
        hold(kbit(2, 0), 80);
        hold(16'h0, 80);
        hold(kbit(3, 1), 40);
        do_reset();
        hold(kbit(3, 1), 100);
        hold(16'h0, 80);
`ifdef KEYPAD_AUTOREPEAT_EN
        hold(kbit(3, 2), 300);
        hold(16'h0, 80);
`endif
        repeat (150) begin
            kind = int'($urandom_range(0, 9));
            m = kind < 3 ? 16'h0 : kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if (kind >= 8) m = m | kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 29) == 0) do_reset();
            if ($urandom_range(0, 4) == 0) bounce(m, int'($urandom_range(8, 40)), int'($urandom_range(1, 6)));
            else hold(m, int'($urandom_range(4, 90)));
        end
        hold(16'h0, 80);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
